// File: rtl/alu_tx_pkg.sv
// Shared state encoding and line-level constants for the ALU result UART transmitter.
package alu_tx_pkg;
  localparam int   DATA_BITS = 8;
  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} tx_state_e;
endpackage

// File: rtl/alu_result_uart_tx_if.sv
// Valid/ready byte stream from the ALU result register into the UART transmitter.
interface alu_result_uart_tx_if;
  import alu_tx_pkg::*;

  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/alu_tx_fifo.sv
// Small synchronous FIFO with occupancy count; registered storage, no bypass.
module alu_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == (PW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers are exactly PW bits wide, so DEPTH being a power of two gives the wrap for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/alu_result_uart_tx.sv
// Streams buffered ALU result bytes out as 8N1 UART frames.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module alu_result_uart_tx
  import alu_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_result_uart_tx_if.slave     in_if,
  output logic                    tx,
  output logic                    busy,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  tx_state_e              state_q;
  logic [BAUD_W-1:0]      baud_q;
  logic [BIT_W-1:0]       bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   tx_q, tx_d;
  logic                   overflow_q;
  logic [DATA_BITS-1:0]   fifo_rd_data;
  logic                   fifo_full, fifo_empty, pop, baud_last;
`ifdef UART_PARITY_EN
  logic                   parity_q;
`endif

  alu_tx_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_if.in_valid),
    .wr_data (in_if.in_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign in_if.in_ready = !fifo_full;
  assign pop            = (state_q == IDLE) && !fifo_empty;
  assign baud_last      = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign tx             = tx_q;
  assign overflow       = overflow_q;
  assign busy           = (state_q != IDLE) || (level != '0);

  // Line level follows the state one cycle later, so tx falls two edges after acceptance.
  always_comb begin
    tx_d = IDLE_LVL;
    case (state_q)
      START:   tx_d = START_LVL;
      DATA:    tx_d = shift_q[0];
`ifdef UART_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= IDLE_LVL;
      overflow_q <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      tx_q <= tx_d;
      if (in_if.in_valid && fifo_full) overflow_q <= 1'b1;
      baud_q <= baud_last ? '0 : baud_q + 1'b1;
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          if (!fifo_empty) begin
            shift_q  <= fifo_rd_data;
            bit_q    <= '0;
`ifdef UART_PARITY_EN
            parity_q <= ^fifo_rd_data;
`endif
            state_q  <= START;
          end
        end
        START: if (baud_last) state_q <= DATA;
        DATA: begin
          if (baud_last) begin
            shift_q <= shift_q >> 1;
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: if (baud_last) state_q <= STOP;
`endif
        STOP: if (baud_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_result_uart_tx.md
Name: alu_result_uart_tx

Overview:
Downstream stage of the 4-bit ALU: takes each registered 8-bit ALU result and streams it off-chip as 8N1 UART frames on a single pin. A small FIFO absorbs bursts of results faster than the line rate. Sits between the ALU result register and a spare output pin.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535
DEPTH, 4, FIFO entries; power of 2, minimum 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_data  input  8  ALU result byte
in_valid  input  1  in_data valid this cycle
in_ready  output  1  FIFO can accept; equals !full
tx  output  1  UART line; idles high
busy  output  1  high while a frame is on the line or the FIFO is non-empty
overflow  output  1  sticky; set when in_valid is asserted while full
level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: tx=1, busy=0, overflow=0, level=0, in_ready=1; FSM in IDLE; FIFO pointers and baud/bit counters cleared.
- Accept: push on in_valid && in_ready. in_valid && !in_ready drops the byte and sets overflow (cleared only by rst).
- FIFO: registered storage, no bypass. A byte pushed at edge N is first visible to the FSM at N+1. Simultaneous push and pop when non-full and non-empty: level unchanged. Push into an empty FIFO while the FSM is IDLE: the pop happens at the following edge, not the same one. Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop, load shift register, clear counters, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit counter runs 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Latency: byte accepted at edge N; tx falls at edge N+2 if idle. Frame length is 10*CLKS_PER_BIT cycles. Back-to-back frames have exactly one IDLE cycle between the end of STOP and the next START.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
- tx is driven from a register, so the output is glitch-free.
- busy = (state != IDLE) || (level != 0).
- Reset mid-frame: at the next edge tx=1, the FIFO is flushed, and the partial frame is abandoned.
- in_ready is combinational from the full flag only, with no dependence on in_valid.

Optional Feature:
Macro UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame length becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; frame is 8N1 as above.

Decomposition:
- Package alu_tx_pkg: FSM state enum (IDLE, START, DATA, STOP, PARITY), DATA_BITS=8, line-level constants IDLE_LVL=1 and START_LVL=0.
- Sub-module alu_tx_fifo (parameter DEPTH): storage, pointers, level, full/empty. Push/pop ports only; no UART knowledge.
- Top module holds the FSM, baud counter, shift register and overflow flag.

Test Plan:
- Reset, then idle 50 cycles -> tx=1, busy=0, in_ready=1, level=0 throughout.
- CLKS_PER_BIT=4; push 0xA5 -> tx falls 2 edges later; line sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy drops after STOP.
- Push 0x01,0x02,0x03,0x04,0x05 on consecutive cycles with DEPTH=4 -> first four accepted. 0x05 is accepted only if the first pop has freed a slot, otherwise dropped with overflow=1. Frames emerge in order, separated by one idle cycle.
- Fill FIFO, hold in_valid high -> in_ready=0, overflow rises and stays 1 until rst.
- Assert rst during DATA bit 3 -> tx=1 next edge, level=0, busy=0; a subsequent push of 0x3C transmits cleanly.
- With UART_PARITY_EN defined: push 0x07 -> parity bit 1 before stop; push 0x03 -> parity bit 0; frames are 44 cycles at CLKS_PER_BIT=4.
